// File: rtl/enabled_delay_line.sv
// Enabled shift-register delay line with a fill tracker and a selectable tap.
// Stages advance only on enabled edges; valid marks a completely filled line.
module enabled_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1,
    localparam int TAPW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic [TAPW-1:0]  tap,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_tap,
    output logic             valid,
    output logic [CNTW-1:0]  fill
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNTW-1:0]  fill_q, fill_d;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Next stage contents: clear zeroes everything, enable shifts d in at stage 0.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end else if (en) begin
            stage_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Fill FSM: counts enabled edges since reset/clear, saturating at DEPTH.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (clr) begin
            state_d = EMPTY;
            fill_d  = '0;
        end else if (en) begin
            unique case (state_q)
                EMPTY: begin
                    fill_d  = CNTW'(1);
                    state_d = (DEPTH == 1) ? FULL : FILLING;
                end
                FILLING: begin
                    fill_d = fill_q + CNTW'(1);
                    if (fill_q == CNTW'(DEPTH - 1)) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    fill_d = fill_q;
                end
                default: begin
                    state_d = EMPTY;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            fill_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Tap mux: taps beyond the last stage read as zero.
    always_comb begin
        q_tap = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (TAPW'(i) == tap) begin
                q_tap = stage_q[i];
            end
        end
    end

    assign q     = stage_q[DEPTH-1];
    assign fill  = fill_q;
    assign valid = (state_q == FULL);

endmodule

// File: tb/tb_enabled_delay_line.sv
// Bench for enabled_delay_line: directed steps plus random traffic on three
// configurations, each checked against a queue-based model of the delay line.
module tb_enabled_delay_line;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: WIDTH=8, DEPTH=4
    logic       a_rst = 0, a_en = 0, a_clr = 0;
    logic [7:0] a_d = 0, a_q, a_qt;
    logic [1:0] a_tap = 0;
    logic       a_valid;
    logic [2:0] a_fill;

    // DUT B: WIDTH=8, DEPTH=3
    logic       b_rst = 0, b_en = 0, b_clr = 0;
    logic [7:0] b_d = 0, b_q, b_qt;
    logic [1:0] b_tap = 0;
    logic       b_valid;
    logic [1:0] b_fill;

    // DUT C: WIDTH=1, DEPTH=1
    logic       c_rst = 0, c_en = 0, c_clr = 0;
    logic [0:0] c_d = 0, c_q, c_qt;
    logic [0:0] c_tap = 0;
    logic       c_valid;
    logic [0:0] c_fill;

    enabled_delay_line #(.WIDTH(8), .DEPTH(4)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .clr(a_clr), .d(a_d),
        .tap(a_tap), .q(a_q), .q_tap(a_qt), .valid(a_valid), .fill(a_fill)
    );

    enabled_delay_line #(.WIDTH(8), .DEPTH(3)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .clr(b_clr), .d(b_d),
        .tap(b_tap), .q(b_q), .q_tap(b_qt), .valid(b_valid), .fill(b_fill)
    );

    enabled_delay_line #(.WIDTH(1), .DEPTH(1)) u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .clr(c_clr), .d(c_d),
        .tap(c_tap), .q(c_q), .q_tap(c_qt), .valid(c_valid), .fill(c_fill)
    );

    // Reference models: newest sample at index 0, count of enabled edges.
    logic [7:0] ma [$];
    int         fa;
    logic [7:0] mb [$];
    int         fb;
    logic       mc;
    int         fc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic a_step(input logic r, input logic c, input logic e,
                          input logic [7:0] dd, input logic [1:0] t);
        a_rst = r; a_clr = c; a_en = e; a_d = dd; a_tap = t;
        @(posedge clk);
        if (r || c) begin
            ma.delete();
            repeat (4) ma.push_back(8'h00);
            fa = 0;
        end else if (e) begin
            ma.push_front(dd);
            void'(ma.pop_back());
            if (fa < 4) fa++;
        end
        #1;
        chk("a_q", 32'(a_q), 32'(ma[3]));
        chk("a_fill", 32'(a_fill), fa);
        chk("a_valid", 32'(a_valid), 32'(fa == 4));
        chk("a_qtap", 32'(a_qt), 32'(ma[t]));
        a_rst = 0; a_clr = 0; a_en = 0;
    endtask

    task automatic b_step(input logic r, input logic c, input logic e,
                          input logic [7:0] dd, input logic [1:0] t);
        b_rst = r; b_clr = c; b_en = e; b_d = dd; b_tap = t;
        @(posedge clk);
        if (r || c) begin
            mb.delete();
            repeat (3) mb.push_back(8'h00);
            fb = 0;
        end else if (e) begin
            mb.push_front(dd);
            void'(mb.pop_back());
            if (fb < 3) fb++;
        end
        #1;
        chk("b_q", 32'(b_q), 32'(mb[2]));
        chk("b_fill", 32'(b_fill), fb);
        chk("b_valid", 32'(b_valid), 32'(fb == 3));
        chk("b_qtap", 32'(b_qt), (t < 3) ? 32'(mb[t]) : 32'h0);
        b_rst = 0; b_clr = 0; b_en = 0;
    endtask

    task automatic c_step(input logic r, input logic e, input logic dd);
        c_rst = r; c_en = e; c_d = dd;
        @(posedge clk);
        if (r) begin
            mc = 1'b0;
            fc = 0;
        end else if (e) begin
            mc = dd;
            fc = 1;
        end
        #1;
        chk("c_q", 32'(c_q), 32'(mc));
        chk("c_fill", 32'(c_fill), fc);
        chk("c_valid", 32'(c_valid), 32'(fc == 1));
        chk("c_qtap", 32'(c_qt), 32'(mc));
        c_rst = 0; c_en = 0;
    endtask

    logic [7:0] exp33 [4];

    initial begin
        exp33 = '{8'h44, 8'h33, 8'h22, 8'h11};

        // Reset with en and d active must still clear everything.
        a_step(1, 0, 1, 8'hFF, 0);
        chk("rst_q", 32'(a_q), 32'h0);
        for (int t = 0; t < 4; t++) begin
            a_tap = 2'(t);
            #1;
            chk("rst_qtap", 32'(a_qt), 32'h0);
        end

        // Continuous enable: 4-edge latency, valid after 4th edge.
        a_step(0, 0, 1, 8'h11, 0);
        a_step(0, 0, 1, 8'h22, 1);
        a_step(0, 0, 1, 8'h33, 2);
        a_step(0, 0, 1, 8'h44, 3);
        chk("cont_q4", 32'(a_q), 32'h11);
        chk("cont_valid4", 32'(a_valid), 32'h1);
        a_step(0, 0, 1, 8'h55, 0);
        chk("cont_q5", 32'(a_q), 32'h22);
        chk("cont_fill5", 32'(a_fill), 32'h4);

        // Alternating enable: only enabled edges count toward latency.
        a_step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) begin
            a_step(0, 0, (i % 2) == 0, 8'(8'hA1 + i), 2'(i));
        end
        chk("alt_q", 32'(a_q), 32'hA1);

        // Tap readout of a full line.
        a_step(1, 0, 0, 8'h00, 0);
        a_step(0, 0, 1, 8'h11, 0);
        a_step(0, 0, 1, 8'h22, 0);
        a_step(0, 0, 1, 8'h33, 0);
        a_step(0, 0, 1, 8'h44, 0);
        for (int t = 0; t < 4; t++) begin
            a_tap = 2'(t);
            #1;
            chk("tap_full", 32'(a_qt), 32'(exp33[t]));
        end

        // Clear mid-fill wins over enable and discards d.
        a_step(1, 0, 0, 8'h00, 0);
        a_step(0, 0, 1, 8'h01, 0);
        a_step(0, 0, 1, 8'h02, 0);
        a_step(0, 1, 1, 8'hFF, 0);
        chk("clr_fill", 32'(a_fill), 32'h0);
        chk("clr_qtap0", 32'(a_qt), 32'h0);
        a_step(0, 0, 1, 8'h5A, 0);
        chk("clr_refill", 32'(a_fill), 32'h1);

        // Random traffic on DEPTH=4.
        for (int i = 0; i < 300; i++) begin
            a_step($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                   1'($urandom_range(0, 1)), 8'($urandom),
                   2'($urandom_range(0, 3)));
        end

        // DEPTH=3: out-of-range tap reads zero even when full.
        b_step(1, 0, 0, 8'h00, 0);
        b_step(0, 0, 1, 8'hC1, 0);
        b_step(0, 0, 1, 8'hC2, 1);
        b_step(0, 0, 1, 8'hC3, 3);
        chk("b_tap3", 32'(b_qt), 32'h0);
        for (int i = 0; i < 80; i++) begin
            b_step($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                   1'($urandom_range(0, 1)), 8'($urandom),
                   2'($urandom_range(0, 3)));
        end

        // DEPTH=1: plain enabled flop, {en,d} cycling 00,01,10,11.
        c_step(1, 0, 0);
        for (int k = 0; k < 12; k++) begin
            c_step(0, (k % 4) >= 2, (k % 2) == 1);
        end
        c_step(1, 1, 1);
        chk("c_midrst_q", 32'(c_q), 32'h0);
        chk("c_midrst_fill", 32'(c_fill), 32'h0);
        for (int i = 0; i < 40; i++) begin
            c_step($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enabled_delay_line.md
ENABLED_DELAY_LINE -- requirements
Module: enabled_delay_line

Interface
REQ-001 Parameter WIDTH, default 1: data width in bits; legal range 1..32.
REQ-002 Parameter DEPTH, default 1: number of register stages; legal range 1..16.
REQ-003 Derived TAPW = max(1, ceil(log2(DEPTH))); CNTW = ceil(log2(DEPTH+1)).
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  shift enable; stages advance only on edges where en=1.
REQ-007 clr  input  1  synchronous clear of stages and fill state.
REQ-008 d  input  WIDTH  data sampled into stage 0 on an enabled edge.
REQ-009 tap  input  TAPW  stage index for q_tap, 0 = newest.
REQ-010 q  output  WIDTH  contents of stage DEPTH-1 (oldest).
REQ-011 q_tap  output  WIDTH  contents of stage[tap], combinational from state and tap.
REQ-012 valid  output  1  high when all DEPTH stages hold data shifted in since last reset/clear.
REQ-013 fill  output  CNTW  count of stages holding shifted-in data, 0..DEPTH.

Function
REQ-014 Priority per edge SHALL be: rst > clr > en > hold.
REQ-015 Enabled edge: stage[0] <= d; stage[i] <= stage[i-1] for i = 1..DEPTH-1.
REQ-016 Edge with en=0 (and no rst/clr): all stages, fill and valid SHALL hold.
REQ-017 Latency: d sampled on the Nth enabled edge SHALL appear on q immediately after the (N+DEPTH-1)th enabled edge; disabled edges do not count.
REQ-018 With DEPTH=1, behaviour SHALL equal a plain enabled D flip-flop: q <= d when en=1, else hold.
REQ-019 Fill state machine with states EMPTY (fill=0), FILLING (0<fill<DEPTH) and FULL (fill=DEPTH).
REQ-020 On an enabled edge, fill SHALL increment by 1 and saturate at DEPTH, giving EMPTY->FILLING->FULL, or EMPTY->FULL when DEPTH=1.
REQ-021 FULL SHALL persist under further enabled edges; only rst or clr leave it, returning to EMPTY.
REQ-022 valid SHALL be 1 exactly when state is FULL; valid is derived from registered state with no combinational path from en or d.
REQ-023 q_tap SHALL be stage[tap] for tap < DEPTH, and all-zero for tap >= DEPTH.
REQ-024 q and fill SHALL be driven directly from registers.
REQ-025 clr=1 with en=1 on the same edge: clear wins, d is discarded, fill=0 afterwards.
REQ-026 clr asserted mid-fill SHALL zero all stages and fill on that edge; the next enabled edge starts a new fill at fill=1.

Reset
REQ-027 On a rising edge with rst=1, all stages SHALL become 0, fill=0, valid=0, regardless of en, clr and d.
REQ-028 After that edge: q=0; q_tap=0 for all tap values; state=EMPTY.
REQ-029 rst asserted mid-operation SHALL behave identically to power-on reset; no asynchronous effect between edges.
REQ-030 Outputs before the first rst edge are undefined; the bench SHALL apply rst for at least 1 cycle first.

Verification
REQ-031 WIDTH=8, DEPTH=4, en=1 every cycle, d=0x11,0x22,0x33,0x44,0x55 -> q=0x11 after 4th edge, 0x22 after 5th; valid rises after 4th edge; fill=1,2,3,4,4.
REQ-032 WIDTH=8, DEPTH=4, en pattern 1,0,1,0,1,0,1 with d=0xA1..0xA7 -> q=0xA1 after the 7th edge (4th enabled edge); fill holds on disabled edges.
REQ-033 DEPTH=4, full with stages 0x44,0x33,0x22,0x11 (newest first) -> tap=0..3 gives q_tap=0x44,0x33,0x22,0x11.
REQ-034 DEPTH=3, TAPW=2, tap=3 -> q_tap=0x00.
REQ-035 DEPTH=4, fill=2, clr=1 and en=1 with d=0xFF on the same edge -> fill=0, valid=0, q=0, 0xFF not captured; next enabled edge gives fill=1.
REQ-036 WIDTH=1, DEPTH=1, clk period 20 ns, {en,d} cycling 00,01,10,11 -> q updates only when en=1, follows d with 1-edge latency; rst mid-run gives q=0 and fill=0 on that edge.
